whirlpool_cipher_ctrl: RTL
==========================

WHIRLPOOL_CIPHER_CTRL -- requirements
Module: whirlpool_cipher_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid  input  1  requester presents key/block.
REQ-004 SHALL have port in_ready  output  1  block accepts a new job.
REQ-005 SHALL have port key  input  [0:511]  cipher key (chaining value H), byte 0 at bits [0:7].
REQ-006 SHALL have port block  input  [0:511]  plaintext (message block m), same byte order.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts result.
REQ-009 SHALL have port out_data  output  [0:511]  cipher result.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL compute the Whirlpool W block cipher: 10 rounds, one shared combinational round instance time-multiplexed between key schedule and state.
REQ-012 SHALL implement FSM states IDLE, KEY, STATE, DONE; in_ready high only in IDLE.
REQ-013 On in_valid && in_ready edge: K <= key, S <= block ^ key, round <= 1, go to KEY.
REQ-014 KEY cycle: round instance idata = K, subkey = RC[round]; K <= result; go to STATE.
REQ-015 STATE cycle: idata = S, subkey = K (already updated); S <= result; round < 10 -> round+1, KEY; round == 10 -> DONE.
REQ-016 RC[r]: row 0 bytes j = S-box[8(r-1)+j], j=0..7; rows 1..7 zero.
REQ-017 Latency: out_valid high exactly 20 clock edges after the accepting edge.
REQ-018 In DONE: out_valid = 1, out_data stable; edge with out_ready returns to IDLE (in_ready high next cycle); no job overlap.
REQ-019 in_valid outside IDLE SHALL be ignored with no state change; key/block sampled only at accept edge.
REQ-020 round counter 4 bits, range 1..10, never wraps; value outside range in KEY/STATE unreachable.

Reset
REQ-021 rst SHALL immediately force IDLE, round=0, K=S=0, out_valid=0, busy=0, in_ready=1 after deassertion.
REQ-022 rst mid-job SHALL discard the job; no out_valid for it.

Configuration
REQ-023 Macro WHIRLPOOL_MP_CHAIN_EN defined: capture H=key and m=block at accept; out_data = S ^ H ^ m (Miyaguchi-Preneel, next chaining value); H,m registers reset to 0.
REQ-024 Macro undefined: out_data = S (raw W output); no H/m registers.

Structure
REQ-025 Package whirlpool_pkg SHALL hold WHIRLPOOL_ROUNDS=10, the 10x64-bit RC row-0 table, and the FSM state enum.
REQ-026 Sub-module: exactly one instance of whirlpool_cipher_round (idata, subkey, odata); operand muxes live in this block.

Verification
REQ-027 MP_CHAIN_EN, key=0, block=0x80 followed by 63 zero bytes -> out_data = 19FA61D75522A466 9B44E39C1D2E1726 C530232130D407F8 9AFEE0964997F7A7 3E83BE698B288FEB CF88E3E03C4F0757 EA8964E59B63D937 08B138CC42A66EB3 (Whirlpool("")), 20 edges after accept.
REQ-028 Macro undefined, same stimulus -> out_data equals reference-model W(0, block) and MP-build output XOR 0x80..00.
REQ-029 out_ready held low 50 cycles in DONE -> out_valid and out_data constant throughout; in_ready low; release -> IDLE next edge.
REQ-030 in_valid pulsed with different key at cycles 3 and 12 of a job -> ignored; result matches first job only.
REQ-031 rst asserted at round 5 STATE -> outputs cleared asynchronously same cycle; next job after release gives correct result in 20 edges.
REQ-032 Back-to-back jobs with out_ready tied high, random key/block x1000 -> every result matches software model, one accept per 22 cycles.

Source files
------------

// File: rtl/whirlpool_pkg.sv
// -----------------------------------------------------------------------------
// whirlpool_pkg
// Shared definitions for the Whirlpool W block cipher controller:
//   - WHIRLPOOL_ROUNDS    : number of W rounds (10)
//   - wp_state_t          : controller FSM state encoding
//   - RC_ROW0             : row 0 of the round constants c^r, r = 1..10
//                           (bytes S[8(r-1)+j], j = 0..7, byte 0 in bits 63:56)
//   - sbox()              : Whirlpool S-box built from the E, E^-1 and R mini-boxes
//   - gf_mul()            : GF(2^8) multiply by a 4-bit constant, poly x^8+x^4+x^3+x^2+1
//   - mix_coef()          : entry d of the circulant MixRows row cir(1,1,4,1,8,5,2,9)
// No ports. The optional Miyaguchi-Preneel output stage (macro WHIRLPOOL_MP_CHAIN_EN)
// lives in the top level and needs nothing from this package.
// -----------------------------------------------------------------------------
package whirlpool_pkg;

  localparam int WHIRLPOOL_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEY   = 2'd1,
    ST_STATE = 2'd2,
    ST_DONE  = 2'd3
  } wp_state_t;

  localparam logic [63:0] RC_ROW0 [1:WHIRLPOOL_ROUNDS] = '{
    64'h1823c6e887b8014f,
    64'h36a6d2f5796f9152,
    64'h60bc9b8ea30c7b35,
    64'h1de0d7c22e4bfe57,
    64'h157737e59ff04ada,
    64'h58c9290ab1a06b85,
    64'hbd5d10f4cb3e0567,
    64'he427418ba77d95d8,
    64'hfbee7c66dd17479e,
    64'hca2dbf07ad5a8333
  };

  // Mini-boxes packed as 16 nibbles, entry 0 in the top nibble.
  localparam logic [63:0] MINI_E    = 64'h1B9CD6F3_E874A250;
  localparam logic [63:0] MINI_EINV = 64'hF0D7BE5A_92C13486;
  localparam logic [63:0] MINI_R    = 64'h7CBDE49F_638A2510;

  // MixRows circulant first row, entry 0 in the top nibble.
  localparam logic [31:0] MIX_ROW0 = 32'h1141_8529;

  function automatic logic [3:0] mini_lookup(input logic [63:0] tbl, input logic [3:0] idx);
    logic [63:0] sh;
    logic [3:0]  pos;
    pos = 4'd15 - idx;
    sh  = tbl >> {pos, 2'b00};
    return sh[3:0];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] u);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    a = mini_lookup(MINI_E, u[7:4]);
    b = mini_lookup(MINI_EINV, u[3:0]);
    c = mini_lookup(MINI_R, a ^ b);
    return {mini_lookup(MINI_E, a ^ c), mini_lookup(MINI_EINV, b ^ c)};
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = gf_xtime(x);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [3:0] mix_coef(input logic [2:0] d);
    logic [31:0] sh;
    logic [2:0]  pos;
    pos = 3'd7 - d;
    sh  = MIX_ROW0 >> {pos, 2'b00};
    return sh[3:0];
  endfunction

  // Round constant as a full 512-bit subkey: row 0 from the table, rows 1..7 zero.
  function automatic logic [0:511] rc_subkey(input logic [3:0] r);
    logic [0:511] v;
    v = '0;
    if (r >= 4'd1 && r <= 4'd10) v[0:63] = RC_ROW0[r];
    return v;
  endfunction

endpackage

// File: rtl/whirlpool_cipher_round.sv
// -----------------------------------------------------------------------------
// whirlpool_cipher_round
// One combinational Whirlpool round rho[subkey]:
//   SubBytes (gamma) -> ShiftColumns (pi) -> MixRows (theta) -> AddRoundKey (sigma).
// The 512-bit state is an 8x8 byte matrix, byte k = row k/8, column k%8,
// byte 0 in bits [0:7].
// Ports:
//   idata  [0:511] in   round input
//   subkey [0:511] in   round key (c^r for the key schedule, K^r for the state)
//   odata  [0:511] out  round output
// -----------------------------------------------------------------------------
module whirlpool_cipher_round
  import whirlpool_pkg::*;
(
  input  logic [0:511] idata,
  input  logic [0:511] subkey,
  output logic [0:511] odata
);

  // gamma and pi merged: column j is rotated down by j rows, so output
  // cell (i,j) takes the S-box of input cell ((i-j) mod 8, j).
  logic [0:511] shifted;

  for (genvar i = 0; i < 8; i++) begin : g_row
    for (genvar j = 0; j < 8; j++) begin : g_col
      localparam int SRC = 8 * ((i - j + 8) % 8) + j;
      localparam int DST = 8 * i + j;
      logic [7:0] mix;

      assign shifted[8*DST +: 8] = sbox(idata[8*SRC +: 8]);

      // theta: row vector times the circulant, C[k][j] = row0[(j-k) mod 8]
      always_comb begin
        mix = subkey[8*DST +: 8];
        for (int k = 0; k < 8; k++) begin
          mix = mix ^ gf_mul(shifted[8*(8*i+k) +: 8], mix_coef(3'((j - k + 8) % 8)));
        end
      end

      assign odata[8*DST +: 8] = mix;
    end
  end

endmodule

// File: rtl/whirlpool_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// whirlpool_cipher_ctrl
// Iterative Whirlpool W block cipher. A single round instance is shared between
// the key schedule (KEY cycle) and the state (STATE cycle), so a job takes 20
// clock edges from accept to out_valid.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   job request (key/block valid)
//   in_ready   out  high only in IDLE
//   key[0:511] in   cipher key / chaining value H, byte 0 in bits [0:7]
//   block[0:511] in plaintext / message block m
//   out_valid  out  high in DONE
//   out_ready  in   consumer takes result; DONE -> IDLE on that edge
//   out_data[0:511] out  cipher result, stable while in DONE
//   busy       out  high in any state but IDLE
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// input side samples key/block only on that edge, the output side holds
// out_data constant until the edge with out_ready.
// Build option WHIRLPOOL_MP_CHAIN_EN: out_data = W ^ H ^ m (Miyaguchi-Preneel
// next chaining value) using H/m captured at accept; otherwise out_data = W.
// -----------------------------------------------------------------------------
module whirlpool_cipher_ctrl
  import whirlpool_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:511] key,
  input  logic [0:511] block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:511] out_data,
  output logic         busy
);

  wp_state_t    state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [0:511] k_q, k_d;
  logic [0:511] s_q, s_d;

  logic [0:511] rnd_idata;
  logic [0:511] rnd_subkey;
  logic [0:511] rnd_odata;

  logic         accept;

  assign accept = in_valid && (state_q == ST_IDLE);

  whirlpool_cipher_round u_round (
    .idata  (rnd_idata),
    .subkey (rnd_subkey),
    .odata  (rnd_odata)
  );

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    k_d        = k_q;
    s_d        = s_q;
    rnd_idata  = s_q;
    rnd_subkey = k_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          k_d     = key;
          s_d     = block ^ key;
          round_d = 4'd1;
          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        rnd_idata  = k_q;
        rnd_subkey = rc_subkey(round_q);
        k_d        = rnd_odata;
        state_d    = ST_STATE;
      end
      ST_STATE: begin
        // Subkey is K^r, already advanced by the preceding KEY cycle.
        rnd_idata  = s_q;
        rnd_subkey = k_q;
        s_d        = rnd_odata;
        if (round_q == 4'(WHIRLPOOL_ROUNDS)) begin
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = ST_KEY;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      k_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      k_q     <= k_d;
      s_q     <= s_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

`ifdef WHIRLPOOL_MP_CHAIN_EN
  logic [0:511] h_q;
  logic [0:511] m_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      m_q <= '0;
    end else if (accept) begin
      h_q <= key;
      m_q <= block;
    end
  end

  assign out_data = s_q ^ h_q ^ m_q;
`else
  assign out_data = s_q;
`endif

endmodule
